// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, write FIFO entry layout and clear FSM encoding
package fb_pkg;
  localparam int FB_ROWS = 256;
  localparam int FB_COLS = 256;
  localparam int NUM_BANKS = 16;
  localparam int READ_BYTES = 10;
  localparam int WFIFO_DEPTH = 4;
  localparam int ADDR_W = 17;
  localparam int BANK_WORDS = 2 * FB_ROWS * FB_COLS / NUM_BANKS;
  localparam int BANK_AW = $clog2(BANK_WORDS);
  localparam int FIFO_AW = $clog2(WFIFO_DEPTH);
  localparam int FIFO_CW = FIFO_AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_ent_t;
endpackage

// File: rtl/fb_bank.sv
// fb_bank: one byte-wide framebuffer bank with a write port and an enabled, registered read port
module fb_bank
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               i_we,
  input  logic [BANK_AW-1:0] i_waddr,
  input  logic [7:0]         i_wdata,
  input  logic               i_re,
  input  logic [BANK_AW-1:0] i_raddr,
  output logic [7:0]         o_rdata
);
  logic [7:0] r_mem [BANK_WORDS];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fb_mem_port.sv
// fb_mem_port: 16-bank framebuffer with 10-byte VGA reads, FIFO-buffered CPU writes and a background clear
module fb_mem_port
  import fb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_bytes,
  input  logic [39:0]             mem_addr,
  output logic [8*READ_BYTES-1:0] input_bytes,
  input  logic                    wr_req,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [7:0]              wr_data,
  output logic                    wr_ready,
  input  logic                    clr_req,
  input  logic                    clr_fb,
  output logic                    clr_busy,
  output logic                    addr_err
);
  state_t             r_state, w_next;
  logic               r_fb, r_zero, r_err;
  logic [11:0]        r_wcnt;
  wr_ent_t            r_fifo [WFIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_CW-1:0] r_cnt;
  logic [3:0]         r_col;
  logic               w_acc, w_drain, w_clr_we, w_bad;
  wr_ent_t            w_head;
  logic [7:0]         w_q [NUM_BANKS];

  assign w_bad    = |mem_addr[39:ADDR_W];
  assign w_head   = r_fifo[r_rp];
  assign wr_ready = r_cnt != FIFO_CW'(WFIFO_DEPTH) && r_state == S_IDLE;
  assign w_acc    = wr_req && wr_ready;
  assign w_drain  = !read_bytes && r_cnt != '0 && r_state != S_CLEAR;
  assign w_clr_we = !read_bytes && r_state == S_CLEAR;
  assign clr_busy = r_state != S_IDLE;
  assign addr_err = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = clr_req ? S_DRAIN : S_IDLE;
      S_DRAIN: w_next = r_cnt == '0 ? S_CLEAR : S_DRAIN;
      S_CLEAR: w_next = w_clr_we && &r_wcnt ? S_IDLE : S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fb   <= 1'b0;
      r_wcnt <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b1;
      r_err  <= 1'b0;
      r_col  <= '0;
    end else begin
      if (r_state == S_IDLE && clr_req) r_fb <= clr_fb;
      r_wcnt <= r_state != S_CLEAR ? '0 : r_wcnt + 12'(w_clr_we);
      if (w_acc) r_wp <= r_wp + FIFO_AW'(1);
      if (w_drain) r_rp <= r_rp + FIFO_AW'(1);
      r_cnt <= r_cnt + FIFO_CW'(w_acc) - FIFO_CW'(w_drain);
      if (read_bytes) begin
        r_zero <= w_bad;
        r_err  <= r_err | w_bad;
        r_col  <= mem_addr[3:0];
      end
    end
  end

  always_ff @(posedge clk)
    if (w_acc) r_fifo[r_wp] <= {wr_addr, wr_data};

  // bank b serves the lane whose column lands on it; the column nibble carries when b wraps below the start
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [3:0] w_hi;
    assign w_hi = mem_addr[7:4] + 4'(4'(b) < mem_addr[3:0]);
    fb_bank u_bank (
      .clk     (clk),
      .i_we    (w_clr_we || (w_drain && w_head.addr[3:0] == 4'(b))),
      .i_waddr (w_clr_we ? {r_fb, r_wcnt} : w_head.addr[ADDR_W-1:4]),
      .i_wdata (w_clr_we ? 8'h00 : w_head.data),
      .i_re    (read_bytes),
      .i_raddr ({mem_addr[16:8], w_hi}),
      .o_rdata (w_q[b])
    );
  end

  for (genvar k = 0; k < READ_BYTES; k++) begin : g_lane
    logic [3:0] w_sel;
    assign w_sel = r_col + 4'(k);
    assign input_bytes[8*k +: 8] = r_zero ? 8'h00 : w_q[w_sel];
  end
endmodule

// File: tb/tb_fb_mem_port.sv
// tb_fb_mem_port: directed checks of reads, wrap, write FIFO, clear and reset abort
module tb_fb_mem_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_bytes = 1'b0;
  logic [39:0] mem_addr = '0;
  logic [79:0] input_bytes;
  logic        wr_req = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        clr_req = 1'b0;
  logic        clr_fb = 1'b0;
  logic        clr_busy;
  logic        addr_err;
  int checks = 0;
  int errors = 0;

  fb_mem_port dut (
    .clk(clk), .rst(rst), .read_bytes(read_bytes), .mem_addr(mem_addr),
    .input_bytes(input_bytes), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_req(clr_req), .clr_fb(clr_fb), .clr_busy(clr_busy),
    .addr_err(addr_err)
  );

  always #20 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [39:0] a);
    @(negedge clk);
    read_bytes = 1'b1;
    mem_addr = a;
    @(negedge clk);
    read_bytes = 1'b0;
  endtask

  task automatic wr_fill(input logic [16:0] a0, input int n, input logic [7:0] d0, input logic inc);
    int i = 0;
    int g = 0;
    @(negedge clk);
    while (i < n && g < 4 * n + 50) begin
      wr_req = 1'b1;
      wr_addr = a0 + 17'(i);
      wr_data = d0 + (inc ? 8'(i) : 8'd0);
      if (wr_ready) i++;
      g++;
      @(negedge clk);
    end
    wr_req = 1'b0;
    checks++;
    if (i != n) begin errors++; $display("FAIL wr_fill %h: accepted %0d required %0d", a0, i, n); end
  endtask

  task automatic test_reset;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (input_bytes !== 80'h0) begin errors++; $display("FAIL reset_data: got %h required 0", input_bytes); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b required 1", wr_ready); end
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b required 0", clr_busy); end
    if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b required 0", addr_err); end
  endtask

  task automatic test_aligned_read;
    wr_fill(17'h00300, 10, 8'h11, 1'b1);
    idle(4);
    rd(40'h00300);
    checks++;
    if (input_bytes !== 80'h1A19_1817_1615_1413_1211) begin errors++; $display("FAIL aligned_read: got %h required 1a191817161514131211", input_bytes); end
    rd(40'h00305);
    checks++;
    if (input_bytes[39:0] !== 40'h1A19181716) begin errors++; $display("FAIL offset_read: got %h required 1a19181716", input_bytes[39:0]); end
    idle(2);
    checks++;
    if (input_bytes[39:0] !== 40'h1A19181716) begin errors++; $display("FAIL read_hold: got %h required 1a19181716", input_bytes[39:0]); end
  endtask

  task automatic test_wrap_read;
    wr_fill(17'h100FC, 4, 8'hA0, 1'b1);
    wr_fill(17'h10000, 6, 8'hB0, 1'b1);
    idle(4);
    rd(40'h100FC);
    checks++;
    if (input_bytes !== 80'hB5B4_B3B2_B1B0_A3A2_A1A0) begin errors++; $display("FAIL wrap_read: got %h required b5b4b3b2b1b0a3a2a1a0", input_bytes); end
  endtask

  task automatic test_read_priority;
    int i = 0;
    int g = 0;
    @(negedge clk);
    read_bytes = 1'b1;
    mem_addr = 40'h00500;
    for (int c = 0; c < 8; c++) begin
      wr_req = 1'b1;
      wr_addr = 17'h00520 + 17'(i);
      wr_data = 8'hC0 + 8'(i);
      if (wr_ready) i++;
      @(negedge clk);
    end
    checks += 2;
    if (i != 4) begin errors++; $display("FAIL prio_accepts: got %0d required 4", i); end
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL prio_full: wr_ready %b required 0", wr_ready); end
    read_bytes = 1'b0;
    while (i < 6 && g < 50) begin
      wr_req = 1'b1;
      wr_addr = 17'h00520 + 17'(i);
      wr_data = 8'hC0 + 8'(i);
      if (wr_ready) i++;
      g++;
      @(negedge clk);
    end
    wr_req = 1'b0;
    idle(6);
    rd(40'h00520);
    checks++;
    if (input_bytes[47:0] !== 48'hC5C4_C3C2_C1C0) begin errors++; $display("FAIL prio_readback: got %h required c5c4c3c2c1c0", input_bytes[47:0]); end
  endtask

  task automatic test_clear;
    int n = 0;
    int g = 0;
    logic ph = 1'b1;
    wr_fill(17'h00000, 256, 8'hFF, 1'b0);
    wr_fill(17'h0FF00, 256, 8'hFF, 1'b0);
    wr_fill(17'h1FF00, 256, 8'hFF, 1'b0);
    idle(4);
    rd(40'h0FF00);
    checks++;
    if (input_bytes !== {10{8'hFF}}) begin errors++; $display("FAIL fill: got %h required all ff", input_bytes); end
    @(negedge clk);
    clr_req = 1'b1;
    clr_fb = 1'b0;
    @(negedge clk);
    clr_req = 1'b0;
    checks++;
    if (clr_busy !== 1'b1) begin errors++; $display("FAIL clr_start: clr_busy %b required 1", clr_busy); end
    while (clr_busy && g < 20000) begin
      read_bytes = ph;
      mem_addr = 40'h1FF80;
      clr_req = g == 100;
      clr_fb = g == 100;
      @(negedge clk);
      if (!ph) n++;
      ph = !ph;
      g++;
    end
    read_bytes = 1'b0;
    clr_req = 1'b0;
    clr_fb = 1'b0;
    checks++;
    if (n != 4096 || clr_busy) begin errors++; $display("FAIL clr_cycles: %0d write cycles busy=%b required 4096 busy=0", n, clr_busy); end
    rd(40'h00000);
    checks++;
    if (input_bytes !== 80'h0) begin errors++; $display("FAIL clr_row0: got %h required 0", input_bytes); end
    rd(40'h0FFFA);
    checks++;
    if (input_bytes !== 80'h0) begin errors++; $display("FAIL clr_row255: got %h required 0", input_bytes); end
    rd(40'h00300);
    checks++;
    if (input_bytes !== 80'h0) begin errors++; $display("FAIL clr_row3: got %h required 0", input_bytes); end
    rd(40'h100FC);
    checks++;
    if (input_bytes !== 80'hB5B4_B3B2_B1B0_A3A2_A1A0) begin errors++; $display("FAIL clr_fb1_row0: got %h required b5b4b3b2b1b0a3a2a1a0", input_bytes); end
    rd(40'h1FF80);
    checks++;
    if (input_bytes !== {10{8'hFF}}) begin errors++; $display("FAIL clr_fb1_row255: got %h required all ff", input_bytes); end
  endtask

  task automatic test_addr_err;
    rd(40'h1_0000_0000);
    checks += 2;
    if (input_bytes !== 80'h0) begin errors++; $display("FAIL err_data: got %h required 0", input_bytes); end
    if (addr_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b required 1", addr_err); end
    rd(40'h1FF80);
    checks += 2;
    if (input_bytes !== {10{8'hFF}}) begin errors++; $display("FAIL err_recover: got %h required all ff", input_bytes); end
    if (addr_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", addr_err); end
  endtask

  task automatic test_clear_abort;
    wr_fill(17'h00630, 48, 8'h55, 1'b0);
    idle(4);
    @(negedge clk);
    clr_req = 1'b1;
    clr_fb = 1'b0;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (101) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 4;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", clr_busy); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL abort_wr_ready: got %b required 1", wr_ready); end
    if (addr_err !== 1'b0) begin errors++; $display("FAIL abort_addr_err: got %b required 0", addr_err); end
    if (input_bytes !== 80'h0) begin errors++; $display("FAIL abort_data: got %h required 0", input_bytes); end
    @(negedge clk);
    rst = 1'b0;
    rd(40'h0063A);
    checks++;
    if (input_bytes !== 80'h5555_5555_0000_0000_0000) begin errors++; $display("FAIL abort_word99_100: got %h required 55555555000000000000", input_bytes); end
    rd(40'h00650);
    checks++;
    if (input_bytes !== {10{8'h55}}) begin errors++; $display("FAIL abort_word101: got %h required all 55", input_bytes); end
  endtask

  initial begin
    test_reset;
    test_aligned_read;
    test_wrap_read;
    test_read_priority;
    test_clear;
    test_addr_err;
    test_clear_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_mem_port.md
FB_MEM_PORT -- requirements
Module: fb_mem_port

Interface
REQ-001 SHALL have clk, input, 1, 25 MHz pixel clock, shared with the VGA controller.
REQ-002 SHALL have rst, input, 1, reset: asynchronous, active-high.
REQ-003 SHALL have read_bytes, input, 1, VGA read request strobe.
REQ-004 SHALL have mem_addr, input, 40, VGA byte address {23'b0, fb, row[7:0], col[7:0]}.
REQ-005 SHALL have input_bytes, output, 80, read data to the VGA controller; byte k in bits [8k+7:8k].
REQ-006 SHALL have wr_req, input, 1, CPU byte-write request.
REQ-007 SHALL have wr_addr, input, 17, CPU byte address {fb, row, col}.
REQ-008 SHALL have wr_data, input, 8, CPU write byte.
REQ-009 SHALL have wr_ready, output, 1, write accepted when wr_req && wr_ready.
REQ-010 SHALL have clr_req, input, 1, single-cycle request to zero-fill framebuffer clr_fb.
REQ-011 SHALL have clr_fb, input, 1, framebuffer to clear; sampled together with clr_req.
REQ-012 SHALL have clr_busy, output, 1, high while a clear is pending or running.
REQ-013 SHALL have addr_err, output, 1, sticky flag: a read arrived with mem_addr[39:17] != 0.

Function
REQ-014 Storage SHALL be 2 framebuffers x 256 x 256 bytes, held as 16 banks; bank = addr[3:0], word = addr[16:4].
REQ-015 A read with read_bytes=1 at edge N SHALL drive input_bytes at edge N with the bytes at addresses a..a+9, a = mem_addr[16:0]; byte k sits in lane k.
REQ-016 Read column SHALL wrap mod 256 within the same row and framebuffer; e.g. col 250 returns cols 250..255 then 0..3.
REQ-017 input_bytes SHALL hold its value until the next read; latency is exactly 1 cycle.
REQ-018 A read with nonzero mem_addr[39:17] SHALL return 80'h0 and set addr_err, which is cleared only by rst.
REQ-019 Writes SHALL pass through a 4-entry FIFO; wr_ready = !full && state==IDLE.
REQ-020 The FIFO head SHALL be written to storage on any cycle with read_bytes=0; on cycles with read_bytes=1, VGA reads have absolute priority and no storage write occurs.
REQ-021 Accept and drain in the same cycle SHALL leave the FIFO count unchanged; a write is never lost or duplicated.
REQ-022 A read never observes a write accepted in the same cycle; it does observe every write drained on an earlier edge.
REQ-023 Clear FSM states: IDLE, DRAIN, CLEAR.
REQ-024 IDLE -> DRAIN on clr_req, latching clr_fb.
REQ-025 clr_req SHALL be ignored outside IDLE.
REQ-026 DRAIN SHALL hold wr_ready=0 and go to CLEAR once the FIFO is empty.
REQ-027 CLEAR SHALL write zero to all 16 banks at one word index per cycle with read_bytes=0, word index running 0..4095 of the latched framebuffer; it stalls on read cycles.
REQ-028 After word 4095 is written, CLEAR SHALL return to IDLE.
REQ-029 clr_busy SHALL equal (state != IDLE).
REQ-030 The clear word counter SHALL be 12 bits and reset to 0 on entry to CLEAR.

Reset
REQ-031 rst SHALL force input_bytes=0, wr_ready=1 (FIFO empty), clr_busy=0, addr_err=0, state IDLE, and all counters/pointers to 0.
REQ-032 rst asserted mid-clear SHALL abort the clear and discard FIFO contents; RAM contents SHALL NOT be reset.

Structure
REQ-033 A shared package fb_pkg SHALL hold FB_ROWS=256, FB_COLS=256, NUM_BANKS=16, READ_BYTES=10, WFIFO_DEPTH=4, and the FSM state encoding.
REQ-034 The design SHALL contain exactly one sub-module, fb_bank: a 8192x8 single-port-write, one-read RAM, instantiated 16 times.

Verification
REQ-035 Write 0x11..0x1A to fb0 row 3 cols 0..9 with read_bytes=0, then read addr 0x00300 -> next cycle input_bytes = 80'h1A19_1817_1615_1413_1211.
REQ-036 Write fb1 row 0 cols 252..255 = 0xA0..0xA3 and cols 0..5 = 0xB0..0xB5, then read addr 0x100FC -> lanes 0..9 = A0,A1,A2,A3,B0,B1,B2,B3,B4,B5.
REQ-037 Hold read_bytes=1 for 8 cycles while issuing 6 back-to-back writes -> wr_ready drops after the 4th accept; all 6 writes land once reads stop, checked by readback.
REQ-038 Fill fb0 with 0xFF, pulse clr_req with clr_fb=0, and toggle read_bytes at 50% -> clr_busy stays high until 4096 zero-write cycles complete; all fb0 reads = 0; fb1 is unchanged.
REQ-039 Read with mem_addr=40'h1_0000_0000 -> input_bytes = 0 and addr_err = 1 until rst.
REQ-040 Assert rst at clear word 100 -> clr_busy=0 and wr_ready=1 at the next edge; fb0 words 100..4095 keep their old data.
